// File: rtl/counter_seq_pkg.sv
// Shared definitions for the counter sequencer: state encoding and default widths.
package counter_seq_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int WRAP_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/updown_counter.sv
// Up/down counter datapath for the sequencer. The FSM decides what happens each
// edge; this block only applies it (load with clipping, clear, reload-to-start,
// or a single step) and reports whether Q sits at the terminal value.
module updown_counter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_clear,
  input  logic             i_reload,
  input  logic             i_step,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_mod_val,
  output logic [WIDTH-1:0] o_q,
  output logic             o_term
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_load_clip;

  // A load never leaves Q outside 0..MOD_VAL.
  assign w_load_clip = (i_load_val < i_mod_val) ? i_load_val : i_mod_val;

  // Up: MOD_VAL or beyond (MOD_VAL may be lowered under Q). Down: zero.
  assign o_term = i_dir ? (r_q >= i_mod_val) : (r_q == '0);

  // Q register: load > clear > reload > step; otherwise hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      // NOTE: non-blocking assignments for every register so all flops sample
      // the same pre-edge values regardless of block evaluation order.
      r_q <= w_load_clip;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_reload) begin
      r_q <= i_dir ? '0 : i_mod_val;
    end else if (i_step) begin
      r_q <= i_dir ? r_q + WIDTH'(1) : r_q - WIDTH'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/counter_sequencer.sv
// Control FSM for a WIDTH-bit modulo counter: start/pause/stop/load commands,
// programmable terminal value, continuous or one-shot modes, a registered
// terminal-count pulse and a saturating count of terminal events.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  input  logic [WIDTH-1:0]  i_mod_val,
  input  logic              i_up_dn,
  input  logic              i_one_shot,
  output logic [WIDTH-1:0]  o_q,
  output logic              o_tc,
  output logic              o_busy,
  output logic              o_done,
  output logic [WRAP_W-1:0] o_wraps
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_tc;
  logic [WRAP_W-1:0] r_wraps;

  logic w_load;
  logic w_clear;
  logic w_reload;
  logic w_step;
  logic w_term;
  logic w_tc_nxt;
  logic w_wrap_inc;
  logic w_wrap_clr;

  updown_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (w_load),
    .i_load_val (i_load_val),
    .i_clear    (w_clear),
    .i_reload   (w_reload),
    .i_step     (w_step),
    .i_dir      (i_up_dn),
    .i_mod_val  (i_mod_val),
    .o_q        (o_q),
    .o_term     (w_term)
  );

  // Next-state and datapath controls; command priority LOAD > STOP > START.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clear     = 1'b0;
    w_reload    = 1'b0;
    w_step      = 1'b0;
    w_tc_nxt    = 1'b0;
    w_wrap_inc  = 1'b0;
    w_wrap_clr  = 1'b0;

    if (i_load) begin
      w_load = 1'b1;
      if (r_state == ST_DONE) w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          // STOP outranks START here and has nothing to do.
          if (!i_stop && i_start) begin
            w_state_nxt = ST_RUN;
            w_wrap_clr  = 1'b1;
          end
        end
        ST_RUN: begin
          if (i_stop) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_term) begin
            w_tc_nxt   = 1'b1;
            w_wrap_inc = 1'b1;
            if (i_one_shot) w_state_nxt = ST_DONE;
            else            w_reload    = 1'b1;
          end else begin
            w_step = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (i_stop) begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
          end else if (i_start) begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_DONE: begin
          if (i_stop) begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
          end else if (i_start) begin
            w_state_nxt = ST_RUN;
            w_reload    = 1'b1;
            w_wrap_clr  = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Terminal-count pulse lands in the cycle Q shows the wrapped/held value.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_tc <= 1'b0;
    else          r_tc <= w_tc_nxt;
  end

  // Saturating terminal-event counter, cleared when a fresh run begins.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wraps <= '0;
    end else if (w_wrap_clr) begin
      r_wraps <= '0;
    end else if (w_wrap_inc && (r_wraps != '1)) begin
      r_wraps <= r_wraps + WRAP_W'(1);
    end
  end

  assign o_tc    = r_tc;
  assign o_wraps = r_wraps;
  assign o_busy  = (r_state == ST_RUN);
  assign o_done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed scenarios plus a random
// phase, all compared against a behavioural model of the command rules.
module tb_counter_sequencer;

  localparam int W  = 4;
  localparam int WW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  mod_val = 4'd9;
  logic          up_dn = 1'b1;
  logic          one_shot = 1'b0;
  logic [W-1:0]  q;
  logic          tc;
  logic          busy;
  logic          done;
  logic [WW-1:0] wraps;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(W), .WRAP_W(WW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_stop     (stop),
    .i_load     (load),
    .i_load_val (load_val),
    .i_mod_val  (mod_val),
    .i_up_dn    (up_dn),
    .i_one_shot (one_shot),
    .o_q        (q),
    .o_tc       (tc),
    .o_busy     (busy),
    .o_done     (done),
    .o_wraps    (wraps)
  );

  // Reference model: mode name, counter value, pulse and wrap count.
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_e;
  mode_e m_st;
  int    m_q;
  int    m_tc;
  int    m_wraps;

  task automatic model_reset();
    m_st = M_IDLE; m_q = 0; m_tc = 0; m_wraps = 0;
  endtask

  // One rising edge of the specified behaviour, using the inputs present now.
  task automatic model_edge();
    int mv;
    mv   = int'(mod_val);
    m_tc = 0;
    if (!rst_n) begin
      model_reset();
    end else if (load) begin
      m_q = (int'(load_val) < mv) ? int'(load_val) : mv;
      if (m_st == M_DONE) m_st = M_IDLE;
    end else begin
      case (m_st)
        M_IDLE:  if (!stop && start) begin m_st = M_RUN; m_wraps = 0; end
        M_RUN: begin
          if (stop) m_st = M_PAUSE;
          else if (up_dn ? (m_q >= mv) : (m_q == 0)) begin
            m_tc = 1;
            if (m_wraps < 255) m_wraps = m_wraps + 1;
            if (one_shot) m_st = M_DONE;
            else          m_q  = up_dn ? 0 : mv;
          end else begin
            m_q = up_dn ? m_q + 1 : m_q - 1;
          end
        end
        M_PAUSE: begin
          if (stop)       begin m_st = M_IDLE; m_q = 0; end
          else if (start) m_st = M_RUN;
        end
        M_DONE: begin
          if (stop)       begin m_st = M_IDLE; m_q = 0; end
          else if (start) begin m_st = M_RUN; m_q = up_dn ? 0 : mv; m_wraps = 0; end
        end
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  function automatic logic [W+WW+2:0] exp_vec();
    logic [W-1:0]  eq;
    logic [WW-1:0] ew;
    eq = W'(m_q);
    ew = WW'(m_wraps);
    return {eq, m_tc != 0, m_st == M_RUN, m_st == M_DONE, ew};
  endfunction

  // Advance the model and the DUT by one edge; sample 1 time unit later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    model_reset();
    tests_run++;
    if ({q, tc, busy, done, wraps} !== exp_vec()) begin
      tests_failed++;
      $display("FAIL reset_state: q=%0d tc=%0b busy=%0b done=%0b wraps=%0d, expected all zero",
               q, tc, busy, done, wraps);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({q, tc, busy, done, wraps} !== exp_vec()) begin
        tests_failed++;
        $display("FAIL idle_after_reset: q=%0d busy=%0b, expected q=0 busy=0", q, busy);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    mod_val = 4'd9; up_dn = 1'b1; one_shot = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (q !== 4'd5 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_count_q: q=%0d busy=%0b, expected q=5 busy=1", q, busy);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if ({q, tc, busy, done, wraps} !== {W'(0), 1'b0, 1'b0, 1'b0, WW'(0)}) begin
      tests_failed++;
      $display("FAIL async_reset: q=%0d tc=%0b busy=%0b wraps=%0d, expected all zero",
               q, tc, busy, wraps);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_continuous_up();
    mod_val = 4'd9; up_dn = 1'b1; one_shot = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      tests_run++;
      if ({q, tc, busy, done, wraps} !== exp_vec()) begin
        tests_failed++;
        $display("FAIL cont_up cyc %0d: q=%0d tc=%0b wraps=%0d, expected q=%0d tc=%0d wraps=%0d",
                 i, q, tc, wraps, m_q, m_tc, m_wraps);
      end
      if (i == 249) begin
        tests_run++;
        if (wraps !== 8'd25 || q !== 4'd0 || tc !== 1'b1) begin
          tests_failed++;
          $display("FAIL wraps_25: wraps=%0d q=%0d tc=%0b, expected 25 0 1", wraps, q, tc);
        end
      end
    end
    tests_run++;
    if (wraps !== 8'd255) begin
      tests_failed++;
      $display("FAIL wraps_saturate: wraps=%0d, expected 255", wraps);
    end
  endtask

  task automatic test_one_shot_down();
    int tc_count;
    stop = 1'b1; tick(); tick(); stop = 1'b0;
    load_val = 4'd3; load = 1'b1; tick(); load = 1'b0;
    tests_run++;
    if (q !== 4'd3 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_3: q=%0d busy=%0b, expected q=3 busy=0", q, busy);
    end
    up_dn = 1'b0; one_shot = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    tc_count = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      tc_count += int'(tc);
      tests_run++;
      if ({q, tc, busy, done, wraps} !== exp_vec()) begin
        tests_failed++;
        $display("FAIL one_shot cyc %0d: q=%0d tc=%0b done=%0b, expected q=%0d tc=%0d done=%0b",
                 i, q, tc, done, m_q, m_tc, m_st == M_DONE);
      end
    end
    tests_run++;
    if (tc_count != 1 || done !== 1'b1 || busy !== 1'b0 || q !== 4'd0) begin
      tests_failed++;
      $display("FAIL one_shot_end: tc_pulses=%0d done=%0b busy=%0b q=%0d, expected 1 1 0 0",
               tc_count, done, busy, q);
    end
    start = 1'b1; tick(); start = 1'b0;
    tests_run++;
    if (q !== 4'd9 || busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL restart_down: q=%0d busy=%0b, expected q=9 busy=1", q, busy);
    end
  endtask

  task automatic test_pause_stop();
    stop = 1'b1; tick(); tick(); stop = 1'b0;
    up_dn = 1'b1; one_shot = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      tests_run++;
      if (q !== 4'd6 || busy !== 1'b0 || tc !== 1'b0 || {q, tc, busy, done, wraps} !== exp_vec()) begin
        tests_failed++;
        $display("FAIL pause_hold cyc %0d: q=%0d busy=%0b tc=%0b, expected q=6 busy=0 tc=0",
                 i, q, busy, tc);
      end
    end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    tests_run++;
    if (q !== 4'd7 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL resume: q=%0d busy=%0b, expected q=7 busy=1", q, busy);
    end
    stop = 1'b1; tick(); tick(); stop = 1'b0;
    tests_run++;
    if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || {q, tc, busy, done, wraps} !== exp_vec()) begin
      tests_failed++;
      $display("FAIL stop_twice: q=%0d busy=%0b done=%0b, expected 0 0 0", q, busy, done);
    end
  endtask

  task automatic test_load_priority();
    mod_val = 4'd5; load_val = 4'd12;
    load = 1'b1; start = 1'b1; tick(); load = 1'b0; start = 1'b0;
    tests_run++;
    if (q !== 4'd5 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_clip_prio: q=%0d busy=%0b, expected q=5 busy=0", q, busy);
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    tests_run++;
    if (q !== 4'd4 || {q, tc, busy, done, wraps} !== exp_vec()) begin
      tests_failed++;
      $display("FAIL reach_4: q=%0d, expected 4", q);
    end
    mod_val = 4'd2;
    tick();
    tests_run++;
    if (q !== 4'd0 || tc !== 1'b1) begin
      tests_failed++;
      $display("FAIL mod_lowered: q=%0d tc=%0b, expected q=0 tc=1", q, tc);
    end
  endtask

  task automatic test_mod_zero_and_flip();
    stop = 1'b1; tick(); tick(); stop = 1'b0;
    mod_val = 4'd0; up_dn = 1'b1; one_shot = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests_run++;
      if (q !== 4'd0 || tc !== 1'b1 || busy !== 1'b1) begin
        tests_failed++;
        $display("FAIL mod_zero cyc %0d: q=%0d tc=%0b busy=%0b, expected 0 1 1", i, q, tc, busy);
      end
    end
    mod_val = 4'd9;
    for (int i = 0; i < 3; i++) tick();
    tests_run++;
    if (q !== 4'd3) begin
      tests_failed++;
      $display("FAIL before_flip: q=%0d, expected 3", q);
    end
    up_dn = 1'b0;
    tick();
    tests_run++;
    if (q !== 4'd2 || tc !== 1'b0 || {q, tc, busy, done, wraps} !== exp_vec()) begin
      tests_failed++;
      $display("FAIL dir_flip: q=%0d tc=%0b, expected q=2 tc=0", q, tc);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      load  = ($urandom_range(0, 15) == 0);
      load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) mod_val  = W'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) up_dn    = ~up_dn;
      if ($urandom_range(0, 29) == 0) one_shot = ~one_shot;
      tick();
      tests_run++;
      if ({q, tc, busy, done, wraps} !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random cyc %0d: q=%0d tc=%0b busy=%0b done=%0b wraps=%0d, expected q=%0d tc=%0d mode=%s wraps=%0d",
                 i, q, tc, busy, done, wraps, m_q, m_tc, m_st.name(), m_wraps);
      end
    end
    start = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reset_mid_count();
    test_continuous_up();
    test_one_shot_down();
    test_pause_stop();
    test_load_priority();
    test_mod_zero_and_flip();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Control FSM plus owned up/down counter datapath that sequences a WIDTH-bit modulo counter for the lab counter designs.
Provides start/pause/stop/load control, a programmable terminal value, continuous or one-shot modes, a terminal-count pulse and a saturating wrap counter.
Sits between board switches/debounced buttons and the display logic, replacing the free-running ripple counter with a synchronous, software-style controllable one.

Parameters:
WIDTH, 4, counter width in bits (Q, LOAD_VAL, MOD_VAL).
WRAP_W, 8, width of saturating wrap counter.

Ports:
CLK  in  1  system clock; all state changes on rising edge.
RST_N  in  1  asynchronous active-low reset.
START  in  1  level, sampled each edge: begin/resume counting.
STOP  in  1  level, sampled each edge: pause, or clear from pause/done.
LOAD  in  1  level, sampled each edge: load Q from LOAD_VAL.
LOAD_VAL  in  WIDTH  value for LOAD.
MOD_VAL  in  WIDTH  terminal value; counts span 0..MOD_VAL inclusive.
UP_DN  in  1  1 = count up, 0 = count down; read live each edge.
ONE_SHOT  in  1  1 = stop at terminal, 0 = wrap continuously; read live.
Q  out  WIDTH  counter value (registered).
TC  out  1  one-cycle registered terminal-count pulse.
BUSY  out  1  high while state is RUN.
DONE  out  1  high while state is DONE.
WRAPS  out  WRAP_W  saturating count of terminal events.

Behaviour:
- Reset (RST_N=0, async): state IDLE, Q=0, TC=0, WRAPS=0. BUSY=0, DONE=0.
- States: IDLE, RUN, PAUSE, DONE. Encoding is 2-bit; BUSY and DONE decode from state.
- Command priority on each edge: LOAD > STOP > START. At most one command acts per edge.
- LOAD, any state:
  - Q <= min(LOAD_VAL, MOD_VAL).
  - No step occurs that edge; TC=0.
  - DONE goes to IDLE; all other states keep their state.
- IDLE:
  - START: go to RUN and clear WRAPS. Q is unchanged.
  - The first step happens on the next edge, so latency is START edge +1.
  - STOP is ignored.
- RUN, without a command, steps once per edge.
  - Terminal condition: up mode when Q >= MOD_VAL; down mode when Q == 0.
  - Not terminal: Q <= Q+1 (up) or Q-1 (down).
  - Terminal with ONE_SHOT=0: Q <= 0 (up) or MOD_VAL (down). TC=1 in the following cycle. WRAPS += 1, saturating at all-ones.
  - Terminal with ONE_SHOT=1: Q holds, TC=1 next cycle, WRAPS += 1 (saturating), state goes to DONE.
  - STOP: go to PAUSE; Q holds.
  - START while already in RUN: no effect.
- PAUSE:
  - Q holds, TC=0.
  - START returns to RUN; counting resumes at the next edge.
  - STOP goes to IDLE with Q <= 0.
- DONE:
  - Q holds, DONE=1.
  - START goes to RUN with Q <= 0 (up) or MOD_VAL (down), and clears WRAPS.
  - STOP goes to IDLE with Q <= 0.
- TC is registered: high exactly in the cycle where Q first shows the wrapped or held terminal result; low in every other cycle.
- Boundary cases:
  - MOD_VAL=0, continuous: Q stays 0 and TC=1 every RUN cycle.
  - MOD_VAL lowered below Q in up mode: the next RUN edge is terminal and wraps to 0.
  - MOD_VAL lowered below Q in down mode: Q decrements normally.
  - UP_DN or ONE_SHOT changing mid-RUN takes effect on the next edge; no glitch and no extra step.
  - LOAD and START together: LOAD wins and START is lost. Requesters hold START for another cycle.
  - RST_N asserted mid-run clears everything immediately.
  - On RST_N release, state stays IDLE until START.

Decomposition:
- Shared package/header counter_seq_pkg: state encodings (ST_IDLE=0, ST_RUN=1, ST_PAUSE=2, ST_DONE=3) and the default WIDTH and WRAP_W constants.
- Sub-module updown_counter holds the Q register. Its controls are load (value), step, dir, and reload-to-terminal. It reports the terminal-condition flag to the FSM in counter_sequencer.

Test Plan:
- Reset mid-count: MOD_VAL=9, UP_DN=1, START for 1 cycle, run 5 edges (Q=5), assert RST_N=0 between edges -> Q=0, TC=0, WRAPS=0, BUSY=0 with no clock edge needed.
- Continuous up wrap: MOD_VAL=9, UP_DN=1, ONE_SHOT=0, START -> Q goes 0,1..9,0. TC=1 only in the cycle Q returns to 0. After 25 wraps WRAPS=25; after 300 wraps WRAPS=255.
- One-shot down: LOAD_VAL=3, LOAD, UP_DN=0, ONE_SHOT=1, START -> Q goes 3,2,1,0, then holds 0. Single TC, DONE=1, BUSY=0. Further START -> Q=MOD_VAL, RUN.
- Pause/stop: count up to Q=6, STOP -> PAUSE, Q=6 held 10 cycles. START -> Q=7 on the next edge. STOP twice -> IDLE with Q=0.
- Load clipping and priority: MOD_VAL=5, LOAD_VAL=12, LOAD+START same edge -> Q=5, state unchanged (IDLE). Then MOD_VAL=2 during up RUN with Q=4 -> next edge Q=0 with TC=1.
- MOD_VAL=0 continuous -> Q=0 and TC=1 on every RUN cycle. Direction flip at Q=3 mid-run -> Q=2 next edge.
